// File: rtl/mem_pkg.sv
// Shared types and defaults for the mem_intf responder.
package mem_pkg;

  localparam int unsigned AddrWDef = 2;
  localparam int unsigned DataWDef = 8;

  typedef enum logic {StInit, StReady} mem_state_t;

  typedef logic [DataWDef-1:0] mem_word_t;

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return pipeline: RdLat stages of valid + data. Data stages only load on a valid
// beat, so the output word holds its last returned value between reads.
module mem_rd_pipe #(
  parameter int unsigned DataW = 8,
  parameter int unsigned RdLat = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [DataW-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [DataW-1:0] out_data_o
);

  logic [RdLat-1:0] valid_q, valid_d;
  logic [DataW-1:0] data_q [RdLat];
  logic [DataW-1:0] data_d [RdLat];

  always_comb begin
    valid_d    = '0;
    valid_d[0] = in_valid_i;
    data_d[0]  = in_valid_i ? in_data_i : data_q[0];
    for (int i = 1; i < RdLat; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < RdLat; i++) data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < RdLat; i++) data_q[i] <= data_d[i];
    end
  end

  assign out_valid_o = valid_q[RdLat-1];
  assign out_data_o  = data_q[RdLat-1];

endmodule

// File: rtl/mem_responder.sv
// Responder end of mem_intf: register-array memory with post-reset clear sweep,
// pipelined reads, access flags and saturating access counters.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned AddrW = AddrWDef,
  parameter int unsigned DataW = DataWDef,
  parameter int unsigned RdLat = 1,
  parameter int unsigned CntW  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  input  logic [DataW-1:0] wr_data_i,
  output logic [DataW-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             ready_o,
  output logic             rw_conflict_o,
  output logic             acc_err_o,
  output logic [CntW-1:0]  wr_cnt_o,
  output logic [CntW-1:0]  rd_cnt_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  mem_state_t       state_q, state_d;
  logic [AddrW-1:0] ptr_q, ptr_d;
  logic [DataW-1:0] mem_q [Depth];
  logic [CntW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0]  rd_cnt_q, rd_cnt_d;
  logic             rw_conflict_q, rw_conflict_d;
  logic             acc_err_q, acc_err_d;
  logic             wr_fire, rd_fire, rdy;

  assign rdy     = (state_q == StReady);
  assign wr_fire = rdy & wr_en_i;
  assign rd_fire = rdy & rd_en_i;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    wr_cnt_d      = wr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    // Single shared address port: a same-cycle read and write always collide.
    rw_conflict_d = wr_fire & rd_fire;
    acc_err_d     = ~rdy & (wr_en_i | rd_en_i);
    unique case (state_q)
      StInit: begin
        ptr_d = ptr_q + AddrW'(1);
        if (ptr_q == AddrW'(Depth - 1)) state_d = StReady;
      end
      StReady: begin
        if (wr_fire && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + CntW'(1);
        if (rd_fire && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + CntW'(1);
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StInit;
      ptr_q         <= '0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      rw_conflict_q <= 1'b0;
      acc_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      rw_conflict_q <= rw_conflict_d;
      acc_err_q     <= acc_err_d;
    end
  end

  // Array is not reset; the INIT sweep clears it after every reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == StInit) begin
        mem_q[ptr_q] <= '0;
      end else if (wr_en_i) begin
        mem_q[addr_i] <= wr_data_i;
      end
    end
  end

  // Array read is taken before the edge, so a same-cycle write is not visible.
  mem_rd_pipe #(
    .DataW (DataW),
    .RdLat (RdLat)
  ) u_rd_pipe (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (rd_fire),
    .in_data_i   (mem_q[addr_i]),
    .out_valid_o (rd_valid_o),
    .out_data_o  (rd_data_o)
  );

  assign ready_o       = rdy;
  assign rw_conflict_o = rw_conflict_q;
  assign acc_err_o     = acc_err_q;
  assign wr_cnt_o      = wr_cnt_q;
  assign rd_cnt_o      = rd_cnt_q;

endmodule
